inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-side counterpart of the control unit. Holds the program counter, addresses program
//  ROM, latches the fetched word into the instruction register (IR), and drives the control unit's
//  instIn. It acts on the fetch/execute states and stackCommand that the control unit issues:
//  sequential fetch, GOTO/CALL/RETLW redirect, skips, computed PCL writes and the 2-level hardware stack.
// PARAMETERS
//  PC_WIDTH      11          program counter / ROM address width (2K words)
//  RESET_VECTOR  {PC_WIDTH{1'b1}}  PC value after reset (last ROM word)
//  STACK_DEPTH   2           hardware stack levels (fixed at 2; other values unsupported)
// PORTS
//  clk           in   1               clock
//  rst_n         in   1               reset, asynchronous, active-low
//  fetchState    in   FE_STATE_BITS   current fetch Q-state from control unit
//  executeState  in   EX_STATE_BITS   current execute state from control unit
//  stackCommand  in   2               STK_PUSH / STK_POP / STK_NOP
//  skipReq       in   1               skip condition true (FSZ result zero / BTFSx bit matches)
//  pageSel       in   PC_WIDTH-9      STATUS PA bits, used as PC upper bits on GOTO/CALL/PCL write
//  pclWe         in   1               execute stage writes file register PCL this cycle
//  pclData       in   8               data written to PCL
//  romData       in   INST_WIDTH      program ROM read data for address romAddr
//  romAddr       out  PC_WIDTH        program ROM address (= PC register)
//  instOut       out  INST_WIDTH      instruction register, feeds control unit instIn
//  stackDepth    out  2               occupied stack levels, 0..2
//  stackErr      out  1               sticky: push at depth 2 or pop at depth 0
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-instruction): PC=RESET_VECTOR, instOut=12'h000 (NOP), stack
//    entries=0, stackDepth=0, stackErr=0. Operation resumes on the first edge after release.
//  - All state updates occur only on the rising edge where fetchState==FE_Q4; otherwise hold.
//    EX_Q4_* always coincides with FE_Q4; an EX_Q4_* state seen outside FE_Q4 is ignored.
//  - Normal edge: instOut<=romData; PC<=PC+1, wrapping from all-ones to 0.
//  - Redirect (instOut<=NOP, the fetched word is flushed, giving a 2-cycle instruction):
//    EX_Q4_GOTO : PC<={pageSel, instOut[8:0]}
//    EX_Q4_CALL : push PC (the return address, already incremented); PC<={pageSel,1'b0,instOut[7:0]}
//    EX_Q4_RETLW: PC<=stack top; pop
//    pclWe=1    : PC<={pageSel,1'b0,pclData}
//  - Skip: EX_Q4_FSZ or EX_Q4_BTFSX with skipReq=1 -> instOut<=NOP, PC<=PC+1.
//  - Priority: reset > GOTO/CALL/RETLW > pclWe > skip > normal. skipReq is ignored in other states.
//  - Stack operations are triggered by stackCommand only, gated by FE_Q4. Code 2'b11 is treated as NOP.
//    push: stk1<=stk0, stk0<=PC; depth saturates at 2; at depth 2 the oldest entry is lost and stackErr is set.
//    pop : top=stk0; stk0<=stk1, stk1 unchanged; depth saturates at 0; at depth 0 the pop still returns
//          stk0 and stackErr is set.
//  - Latency: the ROM word is presented on romAddr during cycle n and appears on instOut after FE_Q4 of cycle n.
//    Redirect takes effect on romAddr right after the EX_Q4 edge; the target word reaches instOut one
//    instruction cycle later.
// STRUCTURE
//  - Shared define.v holds: STK_PUSH/STK_POP/STK_NOP, FE_Q*/EX_Q* encodings, INST_WIDTH and a new
//    I_NOP_12 constant. No local redefinitions.
//  - One sub-module, hw_stack: 2 entries x PC_WIDTH, push/pop/depth/err, async reset.
//  - The top level holds the PC register, IR, next-PC mux and the flush logic.
// TESTING
//  1 Reset: hold rst_n=0 mid-FE_Q2 -> romAddr=11'h7FF, instOut=0, stackDepth=0 immediately (async).
//  2 Sequential: ROM[7FF]=12'hC05 -> instOut=C05 after first FE_Q4; romAddr wraps to 000, then 001.
//  3 GOTO: instOut=12'hA23, pageSel=2'b01, EX_Q4_GOTO -> romAddr=11'h223, next instOut=NOP, then ROM[223].
//  4 CALL/RETLW: CALL 0x40 at addr 0x010 -> romAddr=0x040, depth=1; RETLW -> romAddr=0x011, depth=0.
//  5 Stack error: 3 pushes (return addresses 0x101/0x201/0x301) -> depth=2, stackErr=1; pops return 0x301,
//    0x201, 0x201.
//  6 Skip/PCL: EX_Q4_BTFSX with skipReq=1 -> next instOut=NOP, PC+1; pclWe with pclData=0x80,
//    pageSel=0 -> romAddr=0x080.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared encodings for the fetch side: Q-states, execute states, stack commands,
// instruction width and the 12-bit NOP word.
package inst_fetch_unit_pkg;

  localparam int FE_STATE_BITS = 2;
  localparam int EX_STATE_BITS = 4;
  localparam int INST_WIDTH    = 12;

  localparam logic [INST_WIDTH-1:0] I_NOP_12 = 12'h000;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1 = 2'd0,
    FE_Q2 = 2'd1,
    FE_Q3 = 2'd2,
    FE_Q4 = 2'd3
  } feState_t;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1       = 4'd0,
    EX_Q2       = 4'd1,
    EX_Q3       = 4'd2,
    EX_Q4_NOP   = 4'd3,
    EX_Q4_GOTO  = 4'd4,
    EX_Q4_CALL  = 4'd5,
    EX_Q4_RETLW = 4'd6,
    EX_Q4_FSZ   = 4'd7,
    EX_Q4_BTFSX = 4'd8,
    EX_Q4_OTHER = 4'd9
  } exState_t;

  // Code 2'b11 is deliberately left unnamed; consumers treat it as NOP.
  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stkCmd_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Control-unit / program-ROM side bus of the instruction fetch unit.
interface inst_fetch_unit_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 11
);

  feState_t                fetchState;
  exState_t                executeState;
  logic [1:0]              stackCommand;
  logic                    skipReq;
  logic [PC_WIDTH-10:0]    pageSel;
  logic                    pclWe;
  logic [7:0]              pclData;
  logic [INST_WIDTH-1:0]   romData;
  logic [PC_WIDTH-1:0]     romAddr;
  logic [INST_WIDTH-1:0]   instOut;
  logic [1:0]              stackDepth;
  logic                    stackErr;

  modport master (
    output fetchState, executeState, stackCommand, skipReq, pageSel, pclWe, pclData, romData,
    input  romAddr, instOut, stackDepth, stackErr
  );

  modport slave (
    input  fetchState, executeState, stackCommand, skipReq, pageSel, pclWe, pclData, romData,
    output romAddr, instOut, stackDepth, stackErr
  );

endinterface

// File: rtl/inst_fetch_unit_hw_stack.sv
// Two-level hardware return stack with saturating depth and sticky over/underflow flag.
module hw_stack
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic [1:0]       depth,
  output logic             err
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [WIDTH-1:0] stk0, stk1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk0  <= '0;
      stk1  <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else if (en) begin
      case (cmd)
        STK_PUSH: begin
          stk1 <= stk0;
          stk0 <= pushData;
          if (depth == FULL) err <= 1'b1;
          else               depth <= depth + 2'd1;
        end
        STK_POP: begin
          // stk1 is kept, so popping past one level keeps returning the bottom entry.
          stk0 <= stk1;
          if (depth == 2'd0) err <= 1'b1;
          else               depth <= depth - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign top = stk0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Program counter, instruction register, next-PC selection and flush for the fetch stage.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 11,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1,
  parameter int                  STACK_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.slave   bus
);

  logic [PC_WIDTH-1:0]   pc, pcNext, pcInc, stackTop;
  logic [INST_WIDTH-1:0] ir, irNext;
  logic                  q4;

  assign q4    = (bus.fetchState == FE_Q4);
  assign pcInc = pc + PC_WIDTH'(1);

  // Priority: jumps > PCL write > skip > sequential fetch.
  always_comb begin
    pcNext = pcInc;
    irNext = bus.romData;
    if (bus.executeState == EX_Q4_GOTO) begin
      pcNext = {bus.pageSel, ir[8:0]};
      irNext = I_NOP_12;
    end else if (bus.executeState == EX_Q4_CALL) begin
      pcNext = {bus.pageSel, 1'b0, ir[7:0]};
      irNext = I_NOP_12;
    end else if (bus.executeState == EX_Q4_RETLW) begin
      pcNext = stackTop;
      irNext = I_NOP_12;
    end else if (bus.pclWe) begin
      pcNext = {bus.pageSel, 1'b0, bus.pclData};
      irNext = I_NOP_12;
    end else if (bus.skipReq &&
                 (bus.executeState == EX_Q4_FSZ || bus.executeState == EX_Q4_BTFSX)) begin
      irNext = I_NOP_12;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      ir <= I_NOP_12;
    end else if (q4) begin
      pc <= pcNext;
      ir <= irNext;
    end
  end

  hw_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) uStack (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (q4),
    .cmd      (bus.stackCommand),
    .pushData (pc),
    .top      (stackTop),
    .depth    (bus.stackDepth),
    .err      (bus.stackErr)
  );

  assign bus.romAddr = pc;
  assign bus.instOut = ir;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed instruction cycles queue expected
// post-FE_Q4 state; a monitor compares after every FE_Q4 edge.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  logic clk;
  logic rst_n;

  inst_fetch_unit_if #(.PC_WIDTH(11)) bus ();

  inst_fetch_unit #(
    .PC_WIDTH     (11),
    .RESET_VECTOR (11'h7FF),
    .STACK_DEPTH  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] addr;
    logic [11:0] inst;
    logic [1:0]  depth;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] rom [2048];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.romData = rom[bus.romAddr];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One instruction cycle Q1..Q4; inputs held for the whole cycle, expected state queued.
  task automatic runCycle(input exState_t ex, input logic [1:0] cmd, input logic skip,
                          input logic [1:0] psel, input logic pwe, input logic [7:0] pdat,
                          input logic [10:0] eAddr, input logic [11:0] eInst,
                          input logic [1:0] eDepth, input logic eErr);
    exp_t e;
    @(negedge clk);
    bus.fetchState   = FE_Q1;
    bus.executeState = ex;
    bus.stackCommand = cmd;
    bus.skipReq      = skip;
    bus.pageSel      = psel;
    bus.pclWe        = pwe;
    bus.pclData      = pdat;
    @(negedge clk) bus.fetchState = FE_Q2;
    @(negedge clk) bus.fetchState = FE_Q3;
    @(negedge clk) bus.fetchState = FE_Q4;
    e.addr = eAddr; e.inst = eInst; e.depth = eDepth; e.err = eErr;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.fetchState == FE_Q4 && rst_n) begin
        #1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_q4: romAddr %0h with empty scoreboard", bus.romAddr);
        end else begin
          e = expQ.pop_front();
          checkVal("romAddr",    32'(bus.romAddr),    32'(e.addr));
          checkVal("instOut",    32'(bus.instOut),    32'(e.inst));
          checkVal("stackDepth", 32'(bus.stackDepth), 32'(e.depth));
          checkVal("stackErr",   32'(bus.stackErr),   32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int unsigned i = 0; i < 2048; i++) rom[i] = 12'h800 | 12'(i);
    rom[11'h7FF] = 12'hC05;
    rom[11'h001] = 12'hA23;
    rom[11'h223] = 12'h5A5;
    rom[11'h010] = 12'h940;
    rom[11'h012] = 12'h101;
    rom[11'h201] = 12'hB01;

    rst_n            = 1'b0;
    bus.fetchState   = FE_Q1;
    bus.executeState = EX_Q1;
    bus.stackCommand = STK_NOP;
    bus.skipReq      = 1'b0;
    bus.pageSel      = 2'b00;
    bus.pclWe        = 1'b0;
    bus.pclData      = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runCycle(EX_Q4_NOP, STK_NOP, 1'b0, 2'b00, 1'b0, 8'h00, 11'h000, 12'hC05, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP, STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00, 11'h001, 12'h800, 2'd1, 1'b0);

    // Asynchronous reset in the middle of FE_Q2.
    @(negedge clk) bus.fetchState = FE_Q1;
    bus.stackCommand = STK_NOP;
    @(negedge clk) bus.fetchState = FE_Q2;
    #2 rst_n = 1'b0;
    #1;
    checkVal("rst_romAddr",    32'(bus.romAddr),    32'h7FF);
    checkVal("rst_instOut",    32'(bus.instOut),    32'h000);
    checkVal("rst_stackDepth", 32'(bus.stackDepth), 32'h0);
    checkVal("rst_stackErr",   32'(bus.stackErr),   32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Sequential fetch and wrap, GOTO.
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h000, 12'hC05, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h001, 12'h800, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h002, 12'hA23, 2'd0, 1'b0);
    runCycle(EX_Q4_GOTO,  STK_NOP,  1'b0, 2'b01, 1'b0, 8'h00, 11'h223, 12'h000, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h224, 12'h5A5, 2'd0, 1'b0);
    // PCL write to 0x010, then CALL 0x40 / RETLW.
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b1, 8'h10, 11'h010, 12'h000, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h011, 12'h940, 2'd0, 1'b0);
    runCycle(EX_Q4_CALL,  STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00, 11'h040, 12'h000, 2'd1, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h041, 12'h840, 2'd1, 1'b0);
    runCycle(EX_Q4_RETLW, STK_POP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h011, 12'h000, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h012, 12'h811, 2'd0, 1'b0);
    // Three pushes of 0x101/0x201/0x301, overflow.
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h013, 12'h101, 2'd0, 1'b0);
    runCycle(EX_Q4_GOTO,  STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h101, 12'h000, 2'd0, 1'b0);
    runCycle(EX_Q4_NOP,   STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00, 11'h102, 12'h901, 2'd1, 1'b0);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b01, 1'b1, 8'h01, 11'h201, 12'h000, 2'd1, 1'b0);
    runCycle(EX_Q4_NOP,   STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00, 11'h202, 12'hB01, 2'd2, 1'b0);
    runCycle(EX_Q4_GOTO,  STK_NOP,  1'b0, 2'b01, 1'b0, 8'h00, 11'h301, 12'h000, 2'd2, 1'b0);
    runCycle(EX_Q4_NOP,   STK_PUSH, 1'b0, 2'b00, 1'b0, 8'h00, 11'h302, 12'hB01, 2'd2, 1'b1);
    // Pops return 0x301, 0x201, 0x201 (last one underflows).
    runCycle(EX_Q4_RETLW, STK_POP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h301, 12'h000, 2'd1, 1'b1);
    runCycle(EX_Q4_RETLW, STK_POP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h201, 12'h000, 2'd0, 1'b1);
    runCycle(EX_Q4_RETLW, STK_POP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h201, 12'h000, 2'd0, 1'b1);
    // Skips, ignored skipReq, PCL write, GOTO over PCL priority, command 2'b11.
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h202, 12'hB01, 2'd0, 1'b1);
    runCycle(EX_Q4_BTFSX, STK_NOP,  1'b1, 2'b00, 1'b0, 8'h00, 11'h203, 12'h000, 2'd0, 1'b1);
    runCycle(EX_Q4_FSZ,   STK_NOP,  1'b0, 2'b00, 1'b0, 8'h00, 11'h204, 12'hA03, 2'd0, 1'b1);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b1, 2'b00, 1'b0, 8'h00, 11'h205, 12'hA04, 2'd0, 1'b1);
    runCycle(EX_Q4_NOP,   STK_NOP,  1'b0, 2'b00, 1'b1, 8'h80, 11'h080, 12'h000, 2'd0, 1'b1);
    runCycle(EX_Q4_GOTO,  STK_NOP,  1'b0, 2'b00, 1'b1, 8'h55, 11'h000, 12'h000, 2'd0, 1'b1);
    runCycle(EX_Q4_NOP,   2'b11,    1'b0, 2'b00, 1'b0, 8'h00, 11'h001, 12'h800, 2'd0, 1'b1);
    runCycle(EX_Q4_FSZ,   STK_NOP,  1'b1, 2'b00, 1'b0, 8'h00, 11'h002, 12'h000, 2'd0, 1'b1);

    @(negedge clk) bus.fetchState = FE_Q1;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
